// File: rtl/i2c_pkg.sv
// Shared constants for the I2C core FIFOs.
//   I2C_FIFO_AW      : FIFO address width (depth = 2**I2C_FIFO_AW)
//   I2C_TX_DW        : TX command/data word width
//   I2C_RX_DW        : RX byte width
//   I2C_TX_START_BIT : TX word bit requesting a START before the byte
//   I2C_TX_STOP_BIT  : TX word bit requesting a STOP after the byte
package i2c_pkg;

    localparam int I2C_FIFO_AW      = 4;
    localparam int I2C_TX_DW        = 10;
    localparam int I2C_RX_DW        = 8;
    localparam int I2C_TX_START_BIT = 8;
    localparam int I2C_TX_STOP_BIT  = 9;

endpackage

// File: rtl/i2c_fifo_if.sv
// Handshake/status bundle between a FIFO and its producer/consumer.
//   master : drives wr/wdat/rd/thr, observes rdat and the status flags
//   slave  : the FIFO itself
interface i2c_fifo_if #(
    parameter int DW = 10,
    parameter int AW = 4
);
    logic          wr;
    logic [DW-1:0] wdat;
    logic          rd;
    logic [DW-1:0] rdat;
    logic          full;
    logic          empty;
    logic [AW:0]   ocy;
    logic [AW:0]   thr;
    logic          thr_hit;
    logic          ovf;
    logic          udf;

    modport master (
        output wr, wdat, rd, thr,
        input  rdat, full, empty, ocy, thr_hit, ovf, udf
    );

    modport slave (
        input  wr, wdat, rd, thr,
        output rdat, full, empty, ocy, thr_hit, ovf, udf
    );
endinterface

// File: rtl/i2c_fifo_mem.sv
// Register-array storage for i2c_fifo: one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdat  : write data
//   raddr : read address
//   rdat  : read data, combinational from raddr
module i2c_fifo_mem #(
    parameter int DW = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdat,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem_r [2**AW];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdat;
        end
    end

    assign rdat = mem_r[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO used for the I2C TX and RX paths.
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   srstn : synchronous active-low flush (core soft reset)
//   bus   : slave side of i2c_fifo_if
//           wr/wdat push, rd pop, rdat head word (valid while !empty),
//           full/empty/ocy occupancy, thr/thr_hit threshold compare,
//           ovf/udf one-cycle pulses for a dropped write / ignored read.
module i2c_fifo
    import i2c_pkg::*;
#(
    parameter int DW = I2C_TX_DW,
    parameter int AW = I2C_FIFO_AW
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         srstn,
    i2c_fifo_if.slave    bus
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          ovf_r;
    logic          udf_r;

    logic          full_s;
    logic          empty_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic [AW:0]   count_nxt_s;
    logic [DW-1:0] rdat_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {(AW+1){1'b0}});

    // A write into a full FIFO still succeeds when a read frees a slot in
    // the same cycle; the freed slot is exactly the one wr_ptr points at.
    assign rd_acc_s = bus.rd & ~empty_s;
    assign wr_acc_s = bus.wr & (~full_s | rd_acc_s);

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        if (wr_acc_s && !rd_acc_s) begin
            count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
        end else if (rd_acc_s && !wr_acc_s) begin
            count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, count and error-pulse registers; flush wins over wr/rd
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else if (!srstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
            ovf_r   <= bus.wr & ~wr_acc_s;
            udf_r   <= bus.rd & empty_s;
        end
    end

    i2c_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s & srstn),
        .waddr (wr_ptr_r),
        .wdat  (bus.wdat),
        .raddr (rd_ptr_r),
        .rdat  (rdat_s)
    );

    assign bus.rdat    = rdat_s;
    assign bus.full    = full_s;
    assign bus.empty   = empty_s;
    assign bus.ocy     = count_r;
    assign bus.thr_hit = (count_r > bus.thr);
    assign bus.ovf     = ovf_r;
    assign bus.udf     = udf_r;

endmodule

// File: tb/tb_i2c_fifo.sv
// Self-checking bench for i2c_fifo: a queue-based reference model plus a
// per-cycle compare process and directed literal checks.
module tb_i2c_fifo;

    localparam int DW = 10;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rstn;
    logic srstn;

    i2c_fifo_if #(.DW(DW), .AW(AW)) bus ();

    i2c_fifo #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .srstn (srstn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics straight from the FIFO rules
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
        end else if (!srstn) begin
            q.delete();
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
        end else begin
            automatic bit do_rd = bus.rd && (q.size() > 0);
            automatic bit do_wr = bus.wr && ((q.size() < DEPTH) || do_rd);
            m_udf <= bus.rd && (q.size() == 0);
            m_ovf <= bus.wr && !do_wr;
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(bus.wdat);
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        #1;
        chk("ocy",     32'(bus.ocy),     32'(q.size()));
        chk("empty",   32'(bus.empty),   32'(q.size() == 0));
        chk("full",    32'(bus.full),    32'(q.size() == DEPTH));
        chk("thr_hit", 32'(bus.thr_hit), 32'(q.size() > int'(bus.thr)));
        chk("ovf",     32'(bus.ovf),     32'(m_ovf));
        chk("udf",     32'(bus.udf),     32'(m_udf));
        if (q.size() > 0) chk("rdat", 32'(bus.rdat), 32'(q[0]));
    end

    // One clock cycle with the given strobes; returns 1 time unit after the edge
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        bus.wr   = w;
        bus.wdat = d;
        bus.rd   = r;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        rstn     = 1'b0;
        srstn    = 1'b1;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
        bus.wdat = '0;
        bus.thr  = 5'd16;

        // Reset state
        #3;
        chk("rst_empty",   32'(bus.empty),   32'd1);
        chk("rst_full",    32'(bus.full),    32'd0);
        chk("rst_ocy",     32'(bus.ocy),     32'd0);
        chk("rst_thr_hit", 32'(bus.thr_hit), 32'd0);
        chk("rst_ovf",     32'(bus.ovf),     32'd0);
        chk("rst_udf",     32'(bus.udf),     32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Flush after 3 pushes; write in the flush cycle is overridden
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(i + 7), 1'b0);
        chk("pre_flush_ocy", 32'(bus.ocy), 32'd3);
        @(negedge clk);
        srstn  = 1'b0;
        bus.wr = 1'b1;
        @(posedge clk);
        #1;
        srstn  = 1'b1;
        bus.wr = 1'b0;
        chk("flush_ocy",   32'(bus.ocy),   32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_ovf",   32'(bus.ovf),   32'd0);
        chk("flush_udf",   32'(bus.udf),   32'd0);
        cyc(1'b1, 10'h2A5, 1'b0);
        chk("fwft_rdat", 32'(bus.rdat), 32'h2A5);
        cyc(1'b0, '0, 1'b1);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0);
        chk("fill_ocy",  32'(bus.ocy),  32'd16);
        chk("fill_full", 32'(bus.full), 32'd1);
        cyc(1'b1, 10'h3FF, 1'b0);
        chk("ovf_pulse", 32'(bus.ovf), 32'd1);
        chk("ovf_ocy",   32'(bus.ocy), 32'd16);
        cyc(1'b0, '0, 1'b0);
        chk("ovf_clear", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_rdat", 32'(bus.rdat), 32'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow
        cyc(1'b0, '0, 1'b1);
        chk("udf_pulse", 32'(bus.udf), 32'd1);
        chk("udf_ocy",   32'(bus.ocy), 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("udf_clear", 32'(bus.udf), 32'd0);
        cyc(1'b1, 10'h155, 1'b1);
        chk("wrrd_empty_udf",  32'(bus.udf),  32'd1);
        chk("wrrd_empty_ocy",  32'(bus.ocy),  32'd1);
        chk("wrrd_empty_rdat", 32'(bus.rdat), 32'h155);
        cyc(1'b0, '0, 1'b1);

        // Simultaneous push/pop while full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
        cyc(1'b1, 10'h1AA, 1'b1);
        chk("full_wrrd_ocy", 32'(bus.ocy), 32'd16);
        chk("full_wrrd_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_wrrd_last", 32'(bus.rdat), 32'h1AA);
            cyc(1'b0, '0, 1'b1);
        end

        // Threshold
        bus.thr = 5'd1;
        cyc(1'b1, 10'h011, 1'b0);
        chk("thr1_ocy1", 32'(bus.thr_hit), 32'd0);
        cyc(1'b1, 10'h022, 1'b0);
        chk("thr1_ocy2", 32'(bus.thr_hit), 32'd1);
        bus.thr = 5'd5;
        #1;
        chk("thr5_ocy2", 32'(bus.thr_hit), 32'd0);
        bus.thr = 5'd16;
        for (int i = 0; i < DEPTH - 2; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            chk("thr16", 32'(bus.thr_hit), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);

        // Wrap: interleaved push/pop pairs plus random strobes
        bus.thr = 5'($urandom_range(0, 16));
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
            cyc(1'b0, '0, 1'b1);
            cyc(1'($urandom_range(0, 1)), DW'($urandom_range(0, 1023)),
                1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom_range(0, 1023)), 1'b0);
        bus.thr = 5'd0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_empty",   32'(bus.empty),   32'd1);
        chk("arst_full",    32'(bus.full),    32'd0);
        chk("arst_ocy",     32'(bus.ocy),     32'd0);
        chk("arst_thr_hit", 32'(bus.thr_hit), 32'd0);
        chk("arst_ovf",     32'(bus.ovf),     32'd0);
        chk("arst_udf",     32'(bus.udf),     32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous first-word-fall-through FIFO used twice in the I2C core.
- TX instance: the APB register stage pushes 10-bit command/data words; the byte engine pops them.
- RX instance: the byte engine pushes received bytes; the register stage pops them on reads of the RX data register.
- Reports occupancy and a programmable-threshold flag, which the register stage turns into an interrupt request.
- Reports overflow and underflow pulses, and flushes on the core's soft-reset strobe.

Parameters:
- DW, 10, data word width (TX instance 10, RX instance 8).
- AW, 4, address width; depth = 2**AW = 16 entries.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- srstn  in  1  synchronous soft reset/flush, active-low
- wr  in  1  push strobe, one word per cycle high
- wdat  in  DW  push data
- rd  in  1  pop strobe, one word per cycle high
- rdat  out  DW  head-of-queue data, valid while empty=0
- full  out  1  count == 2**AW
- empty  out  1  count == 0
- ocy  out  AW+1  current count, 0..2**AW
- thr  in  AW+1  threshold level
- thr_hit  out  1  count > thr
- ovf  out  1  one-cycle pulse: write dropped
- udf  out  1  one-cycle pulse: read ignored

Behaviour:
- Storage:
  - 2**AW x DW register array, no reset on contents.
  - wr_ptr and rd_ptr are AW bits and wrap modulo 2**AW.
  - Internal count is AW+1 bits.
- Reset: on rstn low, wr_ptr=0, rd_ptr=0, count=0, ovf=0, udf=0. This gives empty=1, full=0, ocy=0, and thr_hit=(0>thr)=0.
- Soft reset: srstn low at a clock edge has the same effect as reset, synchronously. It overrides wr and rd in the same cycle, and no ovf/udf pulses are produced.
- Write side:
  - Accepted when wr=1 and (full=0 or an accepted read occurs in the same cycle).
  - On acceptance, mem[wr_ptr]<=wdat and wr_ptr increments.
- Read side:
  - rdat = mem[rd_ptr], combinational (FWFT).
  - The consumer samples rdat on the same edge rd is high.
  - Accepted when rd=1 and empty=0; rd_ptr increments.
- Count update: count +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Boundary cases:
  - Full, wr=1 and rd=1: both accepted; count stays 2**AW; the new word is written into the slot just freed.
  - Full, wr only: write dropped; ovf=1 in the next cycle for one cycle; contents unchanged.
  - Empty, rd only: ignored; udf=1 next cycle; rdat is don't-care.
  - Empty, wr=1 and rd=1: read ignored with a udf pulse; write accepted; count becomes 1. The word becomes visible on rdat in the next cycle, so FWFT latency is 1 cycle from push to rdat.
- Flag timing:
  - full, empty, ocy and thr_hit derive combinationally from the registered count and reflect state after the last edge.
  - thr may change at any time; thr_hit follows it combinationally.
- Pointer wrap: after 2**AW pushes and pops, the pointers return to 0 without disturbing count.
- Outputs ovf and udf are registered; all other outputs are combinational from registered state.

Decomposition:
- Shared package i2c_pkg holds:
  - constants I2C_FIFO_AW=4;
  - I2C_TX_DW=10 and I2C_RX_DW=8;
  - the TX word format bits: bit8 = START, bit9 = STOP.
- One natural sub-module, i2c_fifo_mem: a 2**AW x DW register array with write port and asynchronous read port.
- Pointer, count and flag control stay in i2c_fifo.

Test Plan:
- Reset and flush:
  - Push 3 words, then pulse srstn low for 1 cycle -> ocy=0, empty=1, no ovf/udf.
  - Then push 0x2A5 -> rdat=0x2A5 next cycle.
- Fill to full:
  - 16 pushes of 0x000..0x00F -> ocy=16, full=1.
  - A 17th push of 0x3FF -> ovf pulses one cycle, ocy stays 16.
  - 16 pops return 0x000..0x00F in order, followed by empty=1.
- Underflow:
  - rd on empty -> udf high for exactly one cycle, ocy stays 0.
  - Simultaneous wr(0x155)+rd on empty -> udf pulse, ocy=1, rdat=0x155.
- Full simultaneous:
  - At full, wr(0x1AA)+rd in the same cycle -> old head popped, ocy=16, no ovf.
  - Draining then yields 0x1AA last.
- Threshold:
  - thr=1: ocy 0->1 gives thr_hit=0; ocy=2 gives thr_hit=1.
  - Change thr to 5 with ocy=2 -> thr_hit drops the same cycle.
  - thr=16 -> thr_hit never asserts.
- Wrap:
  - 40 interleaved push/pop pairs with random data -> a scoreboard matches every word, with pointers wrapping at 16.
  - Assert rstn low mid-stream -> all flags return to their reset values asynchronously.
